// File: rtl/conv2_pkg.sv
// Shared types, widths and arithmetic helpers for the conv2 single-filter MAC.
// Widths are sized so that no intermediate sum can overflow for any 12-bit pixel / 8-bit weight mix.
package conv2_pkg;

    localparam int DATA_BIT = 12;
    localparam int KSIZE    = 5;
    localparam int NUM_CH   = 3;
    localparam int NTAP     = KSIZE * KSIZE;
    localparam int W_BIT    = 8;
    localparam int PROD_W   = DATA_BIT + W_BIT;
    localparam int PART_W   = PROD_W + $clog2(NTAP);
    localparam int TOT_W    = PART_W + 2;
    localparam int SHIFT    = 6;
    localparam int SAT_W    = 14;

    typedef logic signed [DATA_BIT-1:0] pixel_t;
    typedef logic signed [W_BIT-1:0]    weight_t;
    typedef logic signed [PROD_W-1:0]   prod_t;
    typedef logic signed [PART_W-1:0]   part_t;
    typedef logic signed [TOT_W-1:0]    total_t;
    typedef logic signed [SAT_W-1:0]    sat_t;

    localparam total_t SAT_MAX = TOT_W'(2 ** (SAT_W - 1) - 1);
    localparam total_t SAT_MIN = TOT_W'(-(2 ** (SAT_W - 1)));

    // Operands are widened first so the product is exact in PROD_W bits.
    function automatic prod_t mul_tap(pixel_t p, weight_t w);
        prod_t pe;
        prod_t we;
        pe = {{(PROD_W - DATA_BIT){p[DATA_BIT-1]}}, p};
        we = {{(PROD_W - W_BIT){w[W_BIT-1]}}, w};
        return pe * we;
    endfunction

    function automatic part_t sext_prod(prod_t p);
        return {{(PART_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic total_t sext_part(logic [PART_W-1:0] p);
        return {{(TOT_W - PART_W){p[PART_W-1]}}, p};
    endfunction

    function automatic sat_t sat_shift(total_t tot);
        total_t sh;
        sh = tot >>> SHIFT;
        if (sh > SAT_MAX) begin
            sh = SAT_MAX;
        end else if (sh < SAT_MIN) begin
            sh = SAT_MIN;
        end
        return sh[SAT_W-1:0];
    endfunction

endpackage

// File: rtl/conv2_window_mac_if.sv
// Pixel-in / conv-pixel-out bundle of one conv2 filter; the producer drives the master side.
interface conv2_window_mac_if;
    import conv2_pkg::*;

    logic   valid_in;
    pixel_t pix_1;
    pixel_t pix_2;
    pixel_t pix_3;
    pixel_t conv_out;
    logic   valid_out;

    modport master (output valid_in, pix_1, pix_2, pix_3, input conv_out, valid_out);
    modport slave  (input valid_in, pix_1, pix_2, pix_3, output conv_out, valid_out);

endinterface

// File: rtl/conv2_line_window.sv
// One channel's raster shift buffer exposing a KSIZE x KSIZE window; taps are combinational off the buffer.
// Shifts only on shift_i, so input gaps simply freeze the window (no backpressure).
module conv2_line_window
    import conv2_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              shift_i,
    input  pixel_t                            pix_i,
    output logic [NTAP-1:0][DATA_BIT-1:0]     taps_o
);

    localparam int DEPTH = WIDTH * (KSIZE - 1) + KSIZE;

    // Entry 0 is the newest pixel; older pixels sit WIDTH entries per row further back.
    logic [DEPTH-1:0][DATA_BIT-1:0] shreg_q;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            shreg_q <= '0;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[DEPTH-2:0], pix_i};
        end
    end

    for (genvar r = 0; r < KSIZE; r++) begin : g_row
        for (genvar c = 0; c < KSIZE; c++) begin : g_col
            assign taps_o[r*KSIZE + c] = shreg_q[(KSIZE-1-r)*WIDTH + (KSIZE-1-c)];
        end
    end

endmodule

// File: rtl/conv2_window_mac.sv
// One conv2 output filter: 3-channel 5x5 window MAC, >>>6 saturate, >>>1 plus bias; valid_out 2 cycles after the completing pixel.
// No backpressure: valid_in gaps freeze buffers and counters, the output pipeline always drains.
module conv2_window_mac
    import conv2_pkg::*;
#(
    parameter int                              WIDTH   = 12,
    parameter int                              HEIGHT  = 12,
    parameter logic [NUM_CH*NTAP*W_BIT-1:0]    WEIGHTS = '0,
    parameter logic signed [W_BIT-1:0]         BIAS    = 8'sd0
) (
    input  logic                clk,
    input  logic                rst_n,
    conv2_window_mac_if.slave   bus
);

    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_WIN  = COL_W'(KSIZE - 1);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(KSIZE - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             win_vld_d, win_vld_q;
    logic             s1_vld_q;
    logic             valid_out_q;
    pixel_t           conv_out_q, conv_d;

    logic [NUM_CH-1:0][DATA_BIT-1:0]          pix_ch;
    logic [NUM_CH-1:0][NTAP-1:0][DATA_BIT-1:0] taps;
    logic [NUM_CH-1:0][PART_W-1:0]            partial_d, partial_q;

    total_t total;
    sat_t   t_sat, t_half, t_bias;

    function automatic weight_t weight_at(int idx);
        return WEIGHTS[idx*W_BIT +: W_BIT];
    endfunction

    assign pix_ch = {bus.pix_3, bus.pix_2, bus.pix_1};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        conv2_line_window #(.WIDTH(WIDTH)) u_win (
            .clk     (clk),
            .rst_n   (rst_n),
            .shift_i (bus.valid_in),
            .pix_i   (pix_ch[g]),
            .taps_o  (taps[g])
        );
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (bus.valid_in) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Only fully-inside windows fire, so the buffer never mixes rows or frames.
    assign win_vld_d = bus.valid_in && (col_q >= COL_WIN) && (row_q >= ROW_WIN);

    always_comb begin
        partial_d = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int t = 0; t < NTAP; t++) begin
                partial_d[ch] = partial_d[ch]
                              + sext_prod(mul_tap(taps[ch][t], weight_at(ch * NTAP + t)));
            end
        end
    end

    // Final bias add is done in 14 bits and truncated, so overflow wraps.
    always_comb begin
        total = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            total = total + sext_part(partial_q[ch]);
        end
        t_sat  = sat_shift(total);
        t_half = t_sat >>> 1;
        t_bias = t_half + {{(SAT_W - W_BIT){BIAS[W_BIT-1]}}, BIAS};
        conv_d = t_bias[DATA_BIT-1:0];
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            win_vld_q   <= 1'b0;
            s1_vld_q    <= 1'b0;
            partial_q   <= '0;
            valid_out_q <= 1'b0;
            conv_out_q  <= '0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_vld_q   <= win_vld_d;
            s1_vld_q    <= win_vld_q;
            valid_out_q <= s1_vld_q;
            if (win_vld_q) begin
                partial_q <= partial_d;
            end
            if (s1_vld_q) begin
                conv_out_q <= conv_d;
            end
        end
    end

    assign bus.conv_out  = conv_out_q;
    assign bus.valid_out = valid_out_q;

endmodule

// File: tb/tb_conv2_window_mac.sv
// Four filter instances (random, unity, 127/bias0, 127/bias1) share one pixel stream and are scored against a frame-image model.
module tb_conv2_window_mac;

    localparam int NI = 4;
    localparam int NW = 75;
    localparam int WB = NW * 8;
    localparam int W  = 12;
    localparam int H  = 12;

    function automatic logic [WB-1:0] const_w(input logic [7:0] v);
        logic [WB-1:0] w;
        w = '0;
        for (int i = 0; i < NW; i++) w[i*8 +: 8] = v;
        return w;
    endfunction

    function automatic logic [WB-1:0] rnd_w();
        logic [WB-1:0] w;
        logic [31:0]   s;
        w = '0;
        s = 32'h1234_5678;
        for (int i = 0; i < NW; i++) begin
            s = s * 32'd1664525 + 32'd1013904223;
            w[i*8 +: 8] = s[23:16];
        end
        return w;
    endfunction

    function automatic logic [WB-1:0] inst_w(input int k);
        if (k == 0) return rnd_w();
        if (k == 1) return const_w(8'd1);
        return const_w(8'd127);
    endfunction

    function automatic logic signed [7:0] inst_bias(input int k);
        if (k == 0) return 8'sd3;
        if (k == 3) return 8'sd1;
        return 8'sd0;
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vin = 1'b0;
    logic [11:0] p1 = '0, p2 = '0, p3 = '0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    conv2_window_mac_if bus [NI] ();
    logic [11:0] obs_out [NI];
    logic        obs_vld [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign bus[g].valid_in = vin;
        assign bus[g].pix_1    = p1;
        assign bus[g].pix_2    = p2;
        assign bus[g].pix_3    = p3;
        assign obs_out[g]      = bus[g].conv_out;
        assign obs_vld[g]      = bus[g].valid_out;
        conv2_window_mac #(
            .WIDTH   (W),
            .HEIGHT  (H),
            .WEIGHTS (inst_w(g)),
            .BIAS    (inst_bias(g))
        ) u_dut (
            .clk   (clk),
            .rst_n (rst),
            .bus   (bus[g])
        );
    end

    typedef struct {
        logic [11:0] v;
        int          due;
    } exp_t;

    int          wt [NI][NW];
    int          img [3][H][W];
    int          saved [3][H*W];
    int          mrow = 0, mcol = 0;
    exp_t        exp_q [NI][$];
    logic [11:0] last_v [NI];
    int          n_out [NI];
    int          n_tests = 0, n_fail = 0;
    int          first_pix_cyc = -1, first_out_cyc = -1;
    logic        mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Expected output straight from the window definition over the stored frame image.
    function automatic logic [11:0] ref_out(input int k, input int r0, input int c0);
        int          total, t, o;
        logic [31:0] ob;
        total = 0;
        for (int ch = 0; ch < 3; ch++)
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++)
                    total += wt[k][ch*25 + r*5 + c] * img[ch][r0-4+r][c0-4+c];
        t = total >>> 6;
        if (t > 8191)  t = 8191;
        if (t < -8192) t = -8192;
        o  = (t >>> 1) + int'(inst_bias(k));
        ob = o;
        return ob[11:0];
    endfunction

    task automatic send_pix(input int v1, input int v2, input int v3);
        logic [31:0] b1, b2, b3;
        b1 = v1; b2 = v2; b3 = v3;
        vin = 1'b1;
        p1 = b1[11:0]; p2 = b2[11:0]; p3 = b3[11:0];
        if (first_pix_cyc < 0) first_pix_cyc = cyc + 1;
        img[0][mrow][mcol] = v1;
        img[1][mrow][mcol] = v2;
        img[2][mrow][mcol] = v3;
        if (mrow >= 4 && mcol >= 4)
            for (int k = 0; k < NI; k++) exp_q[k].push_back('{v: ref_out(k, mrow, mcol), due: cyc + 3});
        if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
        @(negedge clk);
    endtask

    // mode: 0 zeros, 1 all 64, 2 all 2047, 3 small random (saved), 4 full random, 5 replay saved
    task automatic run_pixels(input int mode, input int gap, input int npix);
        int v [3];
        for (int i = 0; i < npix; i++) begin
            if (gap > 0 && $urandom_range(0, 2) == 0) begin
                vin = 1'b0;
                p1 = 12'($urandom); p2 = 12'($urandom); p3 = 12'($urandom);
                repeat ($urandom_range(1, gap)) @(negedge clk);
            end
            for (int ch = 0; ch < 3; ch++) begin
                case (mode)
                    0: v[ch] = 0;
                    1: v[ch] = 64;
                    2: v[ch] = 2047;
                    3: begin
                        v[ch] = int'($urandom_range(0, 511)) - 256;
                        saved[ch][i] = v[ch];
                    end
                    4: v[ch] = int'($urandom_range(0, 4095)) - 2048;
                    default: v[ch] = saved[ch][i];
                endcase
            end
            send_pix(v[0], v[1], v[2]);
        end
    endtask

    task automatic drain();
        vin = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        vin = 1'b0;
        for (int k = 0; k < NI; k++) begin
            exp_q[k].delete();
            last_v[k] = '0;
            n_out[k]  = 0;
        end
        mrow = 0;
        mcol = 0;
        first_pix_cyc = -1;
        first_out_cyc = -1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("reset_conv_out[%0d]", k), obs_out[k], 0);
            chk($sformatf("reset_valid_out[%0d]", k), obs_vld[k], 0);
        end
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic chk_counts(input int n);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("outputs_per_run[%0d]", k), n_out[k], n);
            n_out[k] = 0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            for (int k = 0; k < NI; k++) begin
                if (obs_vld[k]) begin
                    if (k == 0 && first_out_cyc < 0) first_out_cyc = cyc;
                    n_out[k]++;
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("spurious_valid[%0d]", k), obs_vld[k], 0);
                    end else begin
                        e = exp_q[k].pop_front();
                        chk($sformatf("out_cycle[%0d]", k), cyc, e.due);
                        chk($sformatf("conv_out[%0d]", k), obs_out[k], e.v);
                        last_v[k] = e.v;
                    end
                end else begin
                    chk($sformatf("hold[%0d]", k), obs_out[k], last_v[k]);
                    if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
                        chk($sformatf("missing_valid[%0d]", k), obs_vld[k], 1);
                        e = exp_q[k].pop_front();
                    end
                end
            end
        end
    end

    initial begin
        logic [WB-1:0] wv;
        logic [7:0]    wb;
        for (int k = 0; k < NI; k++) begin
            wv = inst_w(k);
            for (int i = 0; i < NW; i++) begin
                wb = wv[i*8 +: 8];
                wt[k][i] = int'($signed(wb));
            end
        end

        @(negedge clk);
        do_reset();
        run_pixels(0, 0, H*W);
        run_pixels(1, 0, H*W);
        run_pixels(2, 0, H*W);
        run_pixels(3, 0, H*W);
        drain();
        chk("first_output_latency", first_out_cyc - first_pix_cyc, 54);
        chk_counts(4 * 64);

        run_pixels(5, 3, H*W);
        drain();
        chk_counts(64);

        run_pixels(4, 2, H*W);
        run_pixels(4, 0, H*W);
        drain();
        chk_counts(2 * 64);

        run_pixels(4, 0, 70);
        do_reset();
        run_pixels(3, 1, H*W);
        drain();
        chk_counts(64);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
